// File: rtl/uart_pkg.sv
// Shared types and frame-format decode helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE     = 2'b00,
        PAR_EVEN     = 2'b01,
        PAR_ODD      = 2'b10,
        PAR_NONE_ALT = 2'b11
    } parity_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    localparam int DATA_LEN_MIN = 5;
    localparam int DATA_LEN_MAX = 8;
    localparam int FRAME_W      = DATA_LEN_MAX + 2;

    // cfg_data_bits codes 0..3 select 5..8 data bits; returns the index of the last data bit
    function automatic logic [2:0] last_data_idx(input logic [1:0] code);
        return 3'(code) + 3'(DATA_LEN_MIN - 1);
    endfunction

    function automatic logic parity_enabled(input parity_t p);
        return (p == PAR_EVEN) || (p == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO with a registered head; a full FIFO accepts a push when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_after_pop;
    logic             do_push;
    logic             do_pop;
    logic             full;
    logic             head_valid_nxt;
    logic [WIDTH-1:0] head_data_nxt;

    // The head register is loaded from what will be at the read pointer after this edge,
    // bypassing the incoming word when the FIFO is about to be empty.
    always_comb begin
        do_pop          = pop && (count != '0);
        full            = (count == CW'(DEPTH));
        do_push         = push && (!full || do_pop);
        overflow        = push && !do_push;
        rd_ptr_nxt      = rd_ptr + AW'(do_pop);
        count_after_pop = count - CW'(do_pop);
        head_valid_nxt  = (count_after_pop != '0) || do_push;
        head_data_nxt   = '0;
        if (count_after_pop != '0) begin
            head_data_nxt = mem[rd_ptr_nxt];
        end else if (do_push) begin
            head_data_nxt = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr     <= rd_ptr_nxt;
            count      <= count_after_pop + CW'(do_push);
            head_valid <= head_valid_nxt;
            head_data  <= head_data_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/uart_receiver_cfg.sv
// Oversampling UART receiver with per-frame shadowed format, 2-of-3 bit voting,
// break detection and a small receive FIFO.
module uart_receiver_cfg
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck_rising_edge,
    input  logic       sin,
    input  logic [1:0] cfg_data_bits,
    input  logic [1:0] cfg_parity,
    input  logic       cfg_stop2,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_parity_err,
    output logic       rx_frame_err,
    output logic       overrun,
    output logic       break_det,
    input  logic       clr_status,
    output logic       busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_PRE  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

    rx_state_t        state;
    rx_state_t        state_nxt;
    logic [1:0]       sync_ff;
    logic             sin_s;
    logic [1:0]       win;
    logic             vote;
    logic [TW-1:0]    tick_cnt;
    logic             at_pre;
    logic             at_mid;
    logic             at_last;
    logic [2:0]       bit_idx;
    logic             stop_idx;
    logic [7:0]       data_sr;
    logic             par_bit;
    logic             parity_err_r;
    logic             frame_err_r;
    logic             brk_wait;
    logic [2:0]       sh_last_idx;
    parity_t          sh_parity;
    logic             sh_stop2;
    logic             last_stop;
    logic             expected_par;
    logic             break_hit;
    logic             frame_done;
    logic             push_req;
    logic [FRAME_W-1:0] push_word;
    logic [FRAME_W-1:0] head_word;
    logic             fifo_overflow;

    assign sin_s        = sync_ff[1];
    // win holds the two previous tick samples, so the vote at tick k covers ticks k-2..k
    assign vote         = (win[1] & win[0]) | (win[1] & sin_s) | (win[0] & sin_s);
    assign at_pre       = sck_rising_edge && (tick_cnt == T_PRE);
    assign at_mid       = sck_rising_edge && (tick_cnt == T_MID);
    assign at_last      = sck_rising_edge && (tick_cnt == T_LAST);
    assign last_stop    = !sh_stop2 || stop_idx;
    assign expected_par = (sh_parity == PAR_ODD) ? ~^data_sr : ^data_sr;
    assign busy         = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        break_hit  = 1'b0;
        frame_done = 1'b0;
        if (state == ST_STOP && !brk_wait && at_mid) begin
            break_hit  = !stop_idx && !vote && (data_sr == '0) && !par_bit;
            frame_done = last_stop && !break_hit;
        end
        case (state)
            ST_IDLE: begin
                if (!sin_s) state_nxt = ST_START;
            end
            ST_START: begin
                if (at_pre && vote) state_nxt = ST_IDLE;
                else if (at_last)   state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (at_last && bit_idx == sh_last_idx)
                    state_nxt = parity_enabled(sh_parity) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (at_last) state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (brk_wait) begin
                    if (sin_s) state_nxt = ST_IDLE;
                end else if (frame_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Per-frame datapath: format is shadowed at start so mid-frame cfg changes are ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff      <= 2'b11;
            win          <= 2'b11;
            tick_cnt     <= '0;
            bit_idx      <= '0;
            stop_idx     <= 1'b0;
            data_sr      <= '0;
            par_bit      <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            brk_wait     <= 1'b0;
            sh_last_idx  <= '0;
            sh_parity    <= PAR_NONE;
            sh_stop2     <= 1'b0;
            push_req     <= 1'b0;
            push_word    <= '0;
        end else begin
            sync_ff  <= {sync_ff[0], sin};
            push_req <= frame_done;
            if (sck_rising_edge) begin
                win <= {win[0], sin_s};
            end
            if (frame_done) begin
                push_word <= {frame_err_r | !vote, parity_err_r, data_sr};
            end
            if (state == ST_IDLE) begin
                if (state_nxt == ST_START) begin
                    tick_cnt     <= '0;
                    bit_idx      <= '0;
                    stop_idx     <= 1'b0;
                    data_sr      <= '0;
                    par_bit      <= 1'b0;
                    parity_err_r <= 1'b0;
                    frame_err_r  <= 1'b0;
                    brk_wait     <= 1'b0;
                    sh_last_idx  <= last_data_idx(cfg_data_bits);
                    sh_parity    <= parity_t'(cfg_parity);
                    sh_stop2     <= cfg_stop2;
                end
            end else if (sck_rising_edge) begin
                tick_cnt <= at_last ? '0 : tick_cnt + 1'b1;
                case (state)
                    ST_DATA: begin
                        if (at_mid)  data_sr[bit_idx] <= vote;
                        if (at_last) bit_idx <= bit_idx + 3'd1;
                    end
                    ST_PARITY: begin
                        if (at_mid) begin
                            par_bit      <= vote;
                            parity_err_r <= (vote != expected_par);
                        end
                    end
                    ST_STOP: begin
                        if (at_mid && !brk_wait) begin
                            if (!vote)     frame_err_r <= 1'b1;
                            if (break_hit) brk_wait    <= 1'b1;
                        end
                        if (at_last) stop_idx <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Sticky status: a set in the same cycle as clr_status takes priority
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun   <= 1'b0;
            break_det <= 1'b0;
        end else begin
            overrun   <= fifo_overflow | (overrun & !clr_status);
            break_det <= break_hit | (break_det & !clr_status);
        end
    end

    uart_rx_fifo #(
        .WIDTH(FRAME_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_data (push_word),
        .pop       (rx_ready),
        .head_valid(rx_valid),
        .head_data (head_word),
        .overflow  (fifo_overflow)
    );

    assign {rx_frame_err, rx_parity_err, rx_data} = head_word;

endmodule

// File: tb/tb_uart_receiver_cfg.sv
// Directed bench for uart_receiver_cfg; expected frames go into a scoreboard queue
// and a monitor compares every frame the DUT hands out on a pop.
module tb_uart_receiver_cfg;

    localparam int OVERSAMPLE = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int TICK_DIV   = 4;
    localparam int BIT_CLKS   = OVERSAMPLE * TICK_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sck_rising_edge = 1'b0;
    logic       sin = 1'b1;
    logic [1:0] cfg_data_bits = 2'd3;
    logic [1:0] cfg_parity = 2'b00;
    logic       cfg_stop2 = 1'b0;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_parity_err;
    logic       rx_frame_err;
    logic       overrun;
    logic       break_det;
    logic       clr_status = 1'b0;
    logic       busy;

    logic [9:0] exp_q[$];
    int         vectors = 0;
    int         miscompares = 0;

    uart_receiver_cfg #(
        .OVERSAMPLE(OVERSAMPLE),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sck_rising_edge(sck_rising_edge),
        .sin            (sin),
        .cfg_data_bits  (cfg_data_bits),
        .cfg_parity     (cfg_parity),
        .cfg_stop2      (cfg_stop2),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .rx_data        (rx_data),
        .rx_parity_err  (rx_parity_err),
        .rx_frame_err   (rx_frame_err),
        .overrun        (overrun),
        .break_det      (break_det),
        .clr_status     (clr_status),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (TICK_DIV - 1) @(negedge clk);
            sck_rising_edge = 1'b1;
            @(negedge clk);
            sck_rising_edge = 1'b0;
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
        vectors++;
        if (actual !== required) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
        end
    endtask

    // Monitor: every pop the DUT accepts must match the oldest expected frame
    always @(negedge clk) begin
        if (!rst && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_frame: got 0x%0h, expected no frame",
                         {rx_frame_err, rx_parity_err, rx_data});
            end else begin
                check_output("rx_frame", {22'd0, rx_frame_err, rx_parity_err, rx_data},
                             {22'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic send_bit(input logic b, input int clks);
        sin = b;
        repeat (clks) @(negedge clk);
    endtask

    task automatic set_cfg(input logic [1:0] bits_code, input logic [1:0] par, input logic stop2);
        cfg_data_bits = bits_code;
        cfg_parity    = par;
        cfg_stop2     = stop2;
    endtask

    // par_mode: 0 none, 1 even, 2 odd
    task automatic apply_stimulus(input logic [7:0] d, input int nbits, input int par_mode,
                                  input logic par_flip, input int nstop, input logic last_stop_low);
        logic p;
        p = 1'b0;
        send_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < nbits; i++) begin
            p = p ^ d[i];
            send_bit(d[i], BIT_CLKS);
        end
        if (par_mode != 0) begin
            if (par_mode == 2) p = ~p;
            if (par_flip)      p = ~p;
            send_bit(p, BIT_CLKS);
        end
        for (int s = 0; s < nstop; s++) begin
            if (s == nstop - 1 && last_stop_low) begin
                send_bit(1'b0, BIT_CLKS * 11 / 16);
                send_bit(1'b1, BIT_CLKS * 5 / 16);
            end else begin
                send_bit(1'b1, BIT_CLKS);
            end
        end
        send_bit(1'b1, BIT_CLKS);
    endtask

    task automatic pop_frames(input int n);
        @(posedge clk);
        #2 rx_ready = 1'b1;
        repeat (n) @(posedge clk);
        #2 rx_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int  waited;
        logic seen_busy;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_output("reset_rx_valid", rx_valid, 0);
        check_output("reset_rx_data", rx_data, 0);
        check_output("reset_parity_err", rx_parity_err, 0);
        check_output("reset_frame_err", rx_frame_err, 0);
        check_output("reset_overrun", overrun, 0);
        check_output("reset_break_det", break_det, 0);
        check_output("reset_busy", busy, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] 8N1 0xA5 with rx_ready low");
        set_cfg(2'd3, 2'b00, 1'b0);
        exp_q.push_back({2'b00, 8'hA5});
        apply_stimulus(8'hA5, 8, 0, 1'b0, 1, 1'b0);
        repeat (8) @(negedge clk);
        check_output("8n1_rx_valid", rx_valid, 1);
        check_output("8n1_rx_data", rx_data, 32'hA5);
        check_output("8n1_parity_err", rx_parity_err, 0);
        check_output("8n1_frame_err", rx_frame_err, 0);
        pop_frames(1);
        check_output("8n1_empty_after_pop", rx_valid, 0);

        $display("[TB] 7E1 0x35 with wrong parity");
        set_cfg(2'd2, 2'b01, 1'b0);
        exp_q.push_back({2'b01, 8'h35});
        apply_stimulus(8'h35, 7, 1, 1'b1, 1, 1'b0);
        repeat (8) @(negedge clk);
        check_output("7e1_rx_data", rx_data, 32'h35);
        check_output("7e1_parity_err", rx_parity_err, 1);
        pop_frames(1);

        $display("[TB] 5O2 0x1F with second stop low");
        set_cfg(2'd0, 2'b10, 1'b1);
        exp_q.push_back({2'b10, 8'h1F});
        apply_stimulus(8'h1F, 5, 2, 1'b0, 2, 1'b1);
        repeat (8) @(negedge clk);
        check_output("5o2_rx_data", rx_data, 32'h1F);
        check_output("5o2_frame_err", rx_frame_err, 1);
        pop_frames(1);

        $display("[TB] reset in the middle of a frame");
        set_cfg(2'd3, 2'b00, 1'b0);
        send_bit(1'b0, 3 * BIT_CLKS);
        check_output("midframe_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        sin = 1'b1;
        @(negedge clk);
        check_output("midframe_reset_busy", busy, 0);
        rst = 1'b0;
        send_bit(1'b1, 2 * BIT_CLKS);
        check_output("midframe_no_push", rx_valid, 0);

        $display("[TB] 4-tick start glitch");
        seen_busy = 1'b0;
        sin = 1'b0;
        repeat (4 * TICK_DIV) begin
            @(negedge clk);
            if (busy) seen_busy = 1'b1;
        end
        sin = 1'b1;
        waited = 0;
        while (busy && waited < (OVERSAMPLE / 2 + 3) * TICK_DIV) begin
            @(negedge clk);
            waited++;
        end
        check_output("glitch_busy_seen", seen_busy, 1);
        check_output("glitch_busy_cleared", busy, 0);
        send_bit(1'b1, 2 * BIT_CLKS);
        check_output("glitch_no_push", rx_valid, 0);

        $display("[TB] FIFO overrun with five frames");
        set_cfg(2'd3, 2'b00, 1'b0);
        for (int i = 1; i <= FIFO_DEPTH + 1; i++) begin
            if (i <= FIFO_DEPTH) exp_q.push_back({2'b00, 8'(i)});
            apply_stimulus(8'(i), 8, 0, 1'b0, 1, 1'b0);
        end
        repeat (8) @(negedge clk);
        check_output("overrun_set", overrun, 1);
        check_output("overrun_head_data", rx_data, 32'h01);
        pop_frames(FIFO_DEPTH + 4);
        check_output("overrun_drained", rx_valid, 0);

        $display("[TB] break of 12 bit times");
        check_output("break_clear_before", break_det, 0);
        send_bit(1'b0, 12 * BIT_CLKS);
        check_output("break_det_set", break_det, 1);
        check_output("break_holds_busy", busy, 1);
        send_bit(1'b1, 2 * BIT_CLKS);
        check_output("break_back_idle", busy, 0);
        check_output("break_no_push", rx_valid, 0);
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        @(negedge clk);
        check_output("clr_break_det", break_det, 0);
        check_output("clr_overrun", overrun, 0);

        check_output("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
